// File: rtl/prog_loader.sv
// Program loader: packs a host byte stream (3 bytes per instruction) into
// instruction-memory writes, then hands the memory to the CPU for fetch.
module prog_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int INST_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                cpu_halted,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INST_W-1:0]   mem_wdata,
    output logic                inst_read_writenot,
    output logic [ADDR_W:0]     inst_count,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t              state_q;
    logic                in_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [INST_W-1:0]   wdata_q;
    logic                rw_q;
    logic [ADDR_W:0]     count_q;
    logic                done_q;
    logic                error_q;
    logic                last_q;

    logic                accept_d;
    logic                new_session_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [ADDR_W:0]     count_d;

    // Only the low nibble of the third byte carries instruction bits.
    generate
        if (INST_W < 24) begin : g_hi_unused
            logic unused_hi_s;
            assign unused_hi_s = ^in_data[7:INST_W-16];
        end
    endgenerate

    // Handshake qualifier and increments used by the state register.
    always_comb begin
        accept_d   = in_valid && in_ready_q;
        mem_addr_d = mem_addr_q + ADDR_ONE;
        count_d    = count_q + CNT_ONE;
    end

    // A reload from DONE needs the CPU parked; IDLE and ERR accept start alone.
    always_comb begin
        new_session_d = 1'b0;
        case (state_q)
            S_IDLE:  new_session_d = start;
            S_DONE:  new_session_d = start && cpu_halted;
            S_ERR:   new_session_d = start;
            default: new_session_d = 1'b0;
        endcase
    end

    // Loader FSM with all handshake/status outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b1;
            count_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (new_session_d) begin
                state_q    <= S_B0;
                in_ready_q <= 1'b1;
                rw_q       <= 1'b0;
                mem_addr_q <= '0;
                count_q    <= '0;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                last_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_B0: begin
                        if (accept_d) begin
                            wdata_q[7:0] <= in_data;
                            state_q      <= S_B1;
                        end
                    end
                    S_B1: begin
                        if (accept_d) begin
                            wdata_q[15:8] <= in_data;
                            state_q       <= S_B2;
                        end
                    end
                    S_B2: begin
                        if (accept_d) begin
                            wdata_q[INST_W-1:16] <= in_data[INST_W-17:0];
                            last_q               <= in_last;
                            in_ready_q           <= 1'b0;
                            mem_we_q             <= 1'b1;
                            state_q              <= S_WR;
                        end
                    end
                    S_WR: begin
                        count_q <= count_d;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            rw_q    <= 1'b1;
                            state_q <= S_DONE;
                        end else if (mem_addr_q == ADDR_MAX) begin
                            error_q <= 1'b1;
                            rw_q    <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            mem_addr_q <= mem_addr_d;
                            in_ready_q <= 1'b1;
                            state_q    <= S_B0;
                        end
                    end
                    S_IDLE, S_DONE, S_ERR: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b0;
                        rw_q       <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready           = in_ready_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = wdata_q;
    assign inst_read_writenot = rw_q;
    assign inst_count         = count_q;
    assign done               = done_q;
    assign error              = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: packing, stalls, full/overflow,
// reload gating, async reset and ignored fields.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        cpu_halted;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic        inst_read_writenot;
    logic [5:0]  inst_count;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int base;
    logic [4:0]  wr_addr [0:127];
    logic [19:0] wr_data [0:127];

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .cpu_halted(cpu_halted), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .inst_read_writenot(inst_read_writenot),
        .inst_count(inst_count), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Log every memory write strobe; in_ready must be low while writing.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr[wr_cnt[6:0]] = mem_addr;
            wr_data[wr_cnt[6:0]] = mem_wdata;
            wr_cnt++;
            check("in_ready_low_in_wr", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("byte_accepted", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_inst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic l, input int gap);
        send_byte(b0, 1'b0, gap);
        send_byte(b1, 1'b0, gap);
        send_byte(b2, l, gap);
    endtask

    task automatic start_session(input logic halted);
        start      = 1'b1;
        cpu_halted = halted;
        tick();
        start      = 1'b0;
        cpu_halted = 1'b0;
    endtask

    initial begin
        logic [7:0]  b0, b1, b2;
        logic [19:0] exp_w;
        bit seen_ready;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; cpu_halted = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_wdata", {12'd0, mem_wdata}, 32'd0);
        check("rst_rw", {31'd0, inst_read_writenot}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Single instruction
        start_session(1'b0);
        check("start_in_ready", {31'd0, in_ready}, 32'd1);
        check("start_rw", {31'd0, inst_read_writenot}, 32'd0);
        send_inst(8'h34, 8'h12, 8'hF5, 1'b1, 0);
        check("single_we", {31'd0, mem_we}, 32'd1);
        check("single_addr", {27'd0, mem_addr}, 32'd0);
        check("single_wdata", {12'd0, mem_wdata}, 32'h51234);
        tick();
        check("single_we_drop", {31'd0, mem_we}, 32'd0);
        check("single_done", {31'd0, done}, 32'd1);
        check("single_rw", {31'd0, inst_read_writenot}, 32'd1);
        check("single_count", {26'd0, inst_count}, 32'd1);
        check("single_writes", wr_cnt, 32'd1);

        // Reload gating
        start_session(1'b0);
        tick();
        check("gate_done_kept", {31'd0, done}, 32'd1);
        check("gate_ready_low", {31'd0, in_ready}, 32'd0);
        check("gate_count_kept", {26'd0, inst_count}, 32'd1);
        start_session(1'b1);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_count", {26'd0, inst_count}, 32'd0);
        check("reload_rw", {31'd0, inst_read_writenot}, 32'd0);
        check("reload_ready", {31'd0, in_ready}, 32'd1);

        // Back-pressure and stalls
        base = wr_cnt;
        send_inst(8'h11, 8'h22, 8'h33, 1'b0, $urandom_range(0, 3));
        send_inst(8'hAB, 8'hCD, 8'h0E, 1'b0, $urandom_range(1, 3));
        send_inst(8'h01, 8'h02, 8'h9C, 1'b1, $urandom_range(0, 3));
        tick();
        check("bp_writes", wr_cnt - base, 32'd3);
        check("bp_addr0", {27'd0, wr_addr[base]}, 32'd0);
        check("bp_data0", {12'd0, wr_data[base]}, 32'h32211);
        check("bp_addr1", {27'd0, wr_addr[base+1]}, 32'd1);
        check("bp_data1", {12'd0, wr_data[base+1]}, 32'hECDAB);
        check("bp_addr2", {27'd0, wr_addr[base+2]}, 32'd2);
        check("bp_data2", {12'd0, wr_data[base+2]}, 32'hC0201);
        check("bp_done", {31'd0, done}, 32'd1);
        check("bp_count", {26'd0, inst_count}, 32'd3);

        // Ignored fields: last on a first byte, high nibble of the third byte
        start_session(1'b1);
        send_byte(8'h10, 1'b1, 0);
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'hA7, 1'b0, 0);
        check("ign_wdata", {12'd0, mem_wdata}, 32'h72010);
        tick();
        check("ign_not_done", {31'd0, done}, 32'd0);
        check("ign_continue", {31'd0, in_ready}, 32'd1);
        send_inst(8'h01, 8'h02, 8'h03, 1'b1, 0);
        check("ign_wdata2", {12'd0, mem_wdata}, 32'h30201);
        tick();
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_count", {26'd0, inst_count}, 32'd2);
        check("ign_addr", {27'd0, mem_addr}, 32'd1);

        // Full program of 32 instructions
        start_session(1'b1);
        base = wr_cnt;
        for (int i = 0; i < 32; i++) begin
            b0 = 8'(i * 7 + 1);
            b1 = 8'(255 - i);
            b2 = 8'(i * 17);
            send_inst(b0, b1, b2, (i == 31), 0);
        end
        tick();
        check("full_done", {31'd0, done}, 32'd1);
        check("full_count", {26'd0, inst_count}, 32'd32);
        check("full_addr", {27'd0, mem_addr}, 32'd31);
        check("full_writes", wr_cnt - base, 32'd32);
        for (int i = 0; i < 32; i++) begin
            b0 = 8'(i * 7 + 1);
            b1 = 8'(255 - i);
            b2 = 8'(i * 17);
            exp_w = {b2[3:0], b1, b0};
            check("full_waddr", {27'd0, wr_addr[base+i]}, i);
            check("full_wdata", {12'd0, wr_data[base+i]}, {12'd0, exp_w});
        end

        // Overflow: 32 instructions without last, then a 33rd offered
        start_session(1'b1);
        base = wr_cnt;
        for (int i = 0; i < 32; i++) begin
            send_inst(8'(i), 8'h5A, 8'h03, 1'b0, 0);
        end
        tick();
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_rw", {31'd0, inst_read_writenot}, 32'd1);
        check("ovf_count", {26'd0, inst_count}, 32'd32);
        check("ovf_addr", {27'd0, mem_addr}, 32'd31);
        seen_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 8; i++) begin
            if (in_ready !== 1'b0) seen_ready = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("ovf_never_ready", {31'd0, seen_ready}, 32'd0);
        check("ovf_writes", wr_cnt - base, 32'd32);
        check("ovf_error_sticky", {31'd0, error}, 32'd1);
        start_session(1'b0);
        check("err_restart_error", {31'd0, error}, 32'd0);
        check("err_restart_ready", {31'd0, in_ready}, 32'd1);
        check("err_restart_rw", {31'd0, inst_read_writenot}, 32'd0);

        // Async reset between second and third bytes
        base = wr_cnt;
        send_inst(8'h01, 8'h02, 8'h03, 1'b0, 0);
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h66, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        check("arst_addr", {27'd0, mem_addr}, 32'd0);
        check("arst_wdata", {12'd0, mem_wdata}, 32'd0);
        check("arst_rw", {31'd0, inst_read_writenot}, 32'd1);
        check("arst_count", {26'd0, inst_count}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_error", {31'd0, error}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check("arst_writes", wr_cnt - base, 32'd1);
        check("arst_idle_ready", {31'd0, in_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
